// File: rtl/game_pkg.sv
// Shared game types: state encoding used by the sequencer, renderer and physics.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_AIM   = 3'd2,
    ST_PLAY  = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam logic [2:0] ANGLE_MAX = 3'd5;
  localparam int         LIFE_W    = 3;

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus frame-paced auto-repeat for one held direction button.
module btn_repeat #(
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic btn_i,
  output logic step_o
);

  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       rise;
  logic       rpt;

  assign rise = btn_i & ~prev_q;

  // Counter only runs while the button is held, the owner is listening and
  // the opposite button is not also held; any of those clears it immediately.
  always_comb begin
    cnt_d = cnt_q;
    rpt   = 1'b0;
    if (!en_i || clr_i || !btn_i) begin
      cnt_d = '0;
    end else if (frame_tick_i) begin
      if (cnt_q == 8'(REPEAT_FRAMES - 1)) begin
        cnt_d = '0;
        rpt   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign step_o = en_i & ~clr_i & (rise | rpt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Brick game sequencer: owns game state, aim angle and lives; emits one-cycle
// command pulses to physics and brick memory. All outputs are registered.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES         = 5,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned ANGLE_INIT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              btn_start,
  input  logic              btn_fire,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              ball_lost,
  input  logic              bricks_clear,
  output logic [2:0]        state,
  output logic [2:0]        angle,
  output logic [LIFE_W-1:0] life,
  output logic              launch,
  output logic              serve_reset,
  output logic              field_reset
);

  game_state_e       state_q, state_d;
  logic [2:0]        angle_q, angle_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic [7:0]        frame_q, frame_d;
  logic              launch_q, launch_d;
  logic              srst_q, srst_d;
  logic              frst_q, frst_d;
  logic              start_prev_q, fire_prev_q;
  logic              start_rise, fire_rise;
  logic              in_aim, both_dir, step_l, step_r;

  assign start_rise = btn_start & ~start_prev_q;
  assign fire_rise  = btn_fire & ~fire_prev_q;
  assign in_aim     = (state_q == ST_AIM);
  assign both_dir   = btn_left & btn_right;

  btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_left (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .en_i         (in_aim),
    .clr_i        (both_dir),
    .btn_i        (btn_left),
    .step_o       (step_l)
  );

  btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_right (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .en_i         (in_aim),
    .clr_i        (both_dir),
    .btn_i        (btn_right),
    .step_o       (step_r)
  );

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    life_d   = life_q;
    frame_d  = frame_q;
    launch_d = 1'b0;
    srst_d   = 1'b0;
    frst_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          frst_d  = 1'b1;
          srst_d  = 1'b1;
          life_d  = LIFE_W'(LIVES);
          frame_d = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_q == 8'(SERVE_FRAMES - 1)) begin
            frame_d = '0;
            angle_d = 3'(ANGLE_INIT);
            state_d = ST_AIM;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      ST_AIM: begin
        // Fire takes priority so the ball leaves at the angle the player saw.
        if (fire_rise) begin
          launch_d = 1'b1;
          state_d  = ST_PLAY;
        end else if (step_l && angle_q != 3'd0) begin
          angle_d = angle_q - 3'd1;
        end else if (step_r && angle_q != ANGLE_MAX) begin
          angle_d = angle_q + 3'd1;
        end
      end
      ST_PLAY: begin
        if (bricks_clear) begin
          frst_d  = 1'b1;
          srst_d  = 1'b1;
          frame_d = '0;
          state_d = ST_SERVE;
        end else if (ball_lost) begin
          if (life_q > LIFE_W'(1)) begin
            life_d  = life_q - LIFE_W'(1);
            srst_d  = 1'b1;
            frame_d = '0;
            state_d = ST_SERVE;
          end else begin
            life_d  = '0;
            state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      angle_q      <= 3'(ANGLE_INIT);
      life_q       <= '0;
      frame_q      <= '0;
      launch_q     <= 1'b0;
      srst_q       <= 1'b0;
      frst_q       <= 1'b0;
      start_prev_q <= 1'b1;
      fire_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      life_q       <= life_d;
      frame_q      <= frame_d;
      launch_q     <= launch_d;
      srst_q       <= srst_d;
      frst_q       <= frst_d;
      start_prev_q <= btn_start;
      fire_prev_q  <= btn_fire;
    end
  end

  assign state       = state_q;
  assign angle       = angle_q;
  assign life        = life_q;
  assign launch      = launch_q;
  assign serve_reset = srst_q;
  assign field_reset = frst_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector tables plus multi-cycle sequences.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0, btn_start = 1'b0, btn_fire = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, ball_lost = 1'b0, bricks_clear = 1'b0;
  logic [2:0] state, angle, life;
  logic       launch, serve_reset, field_reset;

  game_ctrl #(
    .LIVES(5), .SERVE_FRAMES(60), .REPEAT_FRAMES(8), .ANGLE_INIT(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_start    (btn_start),
    .btn_fire     (btn_fire),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .ball_lost    (ball_lost),
    .bricks_clear (bricks_clear),
    .state        (state),
    .angle        (angle),
    .life         (life),
    .launch       (launch),
    .serve_reset  (serve_reset),
    .field_reset  (field_reset)
  );

  always #5 clk = ~clk;

  // Input bits: {rst, start, fire, left, right, tick, lost, clear}; R = run (rst high).
  localparam logic [7:0] R = 8'h80, I_START = 8'h40, I_FIRE = 8'h20, I_LEFT = 8'h10;
  localparam logic [7:0] I_RIGHT = 8'h08, I_TICK = 8'h04, I_LOST = 8'h02, I_CLR = 8'h01;

  typedef struct packed {
    logic [95:0] name;
    logic [7:0]  in;
    logic [11:0] exp;
  } vec_t;

  logic [11:0] exp_q[$];
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [11:0] ex(input int st, input int ang, input int lf,
                                     input bit la, input bit sr, input bit fr);
    return {3'(st), 3'(ang), 3'(lf), la, sr, fr};
  endfunction

  function automatic vec_t mk(input logic [95:0] nm, input logic [7:0] in, input logic [11:0] e);
    vec_t v;
    v.name = nm;
    v.in   = in;
    v.exp  = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [11:0] want, got;
    @(negedge clk);
    {rst, btn_start, btn_fire, btn_left, btn_right, frame_tick, ball_lost, bricks_clear} = v.in;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    got  = {state, angle, life, launch, serve_reset, field_reset};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %0s: got st=%0d ang=%0d life=%0d la/sr/fr=%b%b%b, want st=%0d ang=%0d life=%0d la/sr/fr=%b%b%b",
               v.name, got[11:9], got[8:6], got[5:3], got[2], got[1], got[0],
               want[11:9], want[8:6], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  // Sixty frame ticks in SERVE; the last one moves to AIM with the angle reloaded.
  task automatic serve(input int ang, input int lf, input logic [7:0] extra);
    for (int i = 0; i < 60; i++) begin
      if (i == 59) apply(mk("serve_end", R | I_TICK | extra, ex(2, 2, lf, 0, 0, 0)));
      else         apply(mk("serve_tick", R | I_TICK | extra, ex(1, ang, lf, 0, 0, 0)));
    end
  endtask

  initial begin
    int a;
    // Reset, start held through reset, ignored events in IDLE, game start.
    tbl.push_back(mk("rst0",       8'h00,                          ex(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mk("rst_start",  I_START,                        ex(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mk("idle_held",  R | I_START,                    ex(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mk("idle_rel",   R,                              ex(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mk("idle_evts",  R | I_LOST | I_CLR | I_TICK | I_FIRE, ex(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mk("start",      R | I_START,                    ex(1, 2, 5, 0, 1, 1)));
    tbl.push_back(mk("start_hold", R | I_START,                    ex(1, 2, 5, 0, 0, 0)));
    tbl.push_back(mk("serve_q",    R,                              ex(1, 2, 5, 0, 0, 0)));
    run_table();
    serve(2, 5, 8'h00);

    // AIM: right press, auto-repeat on ticks only, saturation, both held, fire+step.
    tbl.push_back(mk("right_rise", R | I_RIGHT, ex(2, 3, 5, 0, 0, 0)));
    for (int t = 1; t <= 24; t++) begin
      a = (t < 8) ? 3 : (t < 16) ? 4 : 5;
      tbl.push_back(mk("rpt_tick", R | I_RIGHT | I_TICK, ex(2, a, 5, 0, 0, 0)));
      tbl.push_back(mk("rpt_hold", R | I_RIGHT,          ex(2, a, 5, 0, 0, 0)));
    end
    tbl.push_back(mk("right_rel", R, ex(2, 5, 5, 0, 0, 0)));
    tbl.push_back(mk("both_rise", R | I_LEFT | I_RIGHT, ex(2, 5, 5, 0, 0, 0)));
    for (int t = 0; t < 10; t++)
      tbl.push_back(mk("both_tick", R | I_LEFT | I_RIGHT | I_TICK, ex(2, 5, 5, 0, 0, 0)));
    tbl.push_back(mk("both_rel",   R,                  ex(2, 5, 5, 0, 0, 0)));
    tbl.push_back(mk("left_rise",  R | I_LEFT,         ex(2, 4, 5, 0, 0, 0)));
    tbl.push_back(mk("left_rel",   R,                  ex(2, 4, 5, 0, 0, 0)));
    tbl.push_back(mk("fire_step",  R | I_FIRE | I_LEFT, ex(3, 4, 5, 1, 0, 0)));
    tbl.push_back(mk("launch_end", R,                  ex(3, 4, 5, 0, 0, 0)));
    tbl.push_back(mk("lost_clr",   R | I_LOST | I_CLR, ex(1, 4, 5, 0, 1, 1)));
    tbl.push_back(mk("clr_end",    R,                  ex(1, 4, 5, 0, 0, 0)));
    run_table();
    serve(4, 5, 8'h00);

    // Lose lives down to one, each loss re-serving.
    for (int lf = 5; lf >= 2; lf--) begin
      apply(mk("fire",     R | I_FIRE, ex(3, 2, lf, 1, 0, 0)));
      apply(mk("play",     R,          ex(3, 2, lf, 0, 0, 0)));
      apply(mk("lost",     R | I_LOST, ex(1, 2, lf - 1, 0, 1, 0)));
      serve(2, lf - 1, 8'h00);
    end
    apply(mk("fire_last",  R | I_FIRE,          ex(3, 2, 1, 1, 0, 0)));
    apply(mk("play_last",  R,                   ex(3, 2, 1, 0, 0, 0)));
    apply(mk("lost_over",  R | I_LOST,          ex(4, 2, 0, 0, 0, 0)));
    apply(mk("over_evts",  R | I_LOST | I_FIRE, ex(4, 2, 0, 0, 0, 0)));
    apply(mk("over_start", R | I_START,         ex(0, 2, 0, 0, 0, 0)));
    apply(mk("idle_again", R,                   ex(0, 2, 0, 0, 0, 0)));

    // Reset mid-AIM with buttons held, then a fresh fire rise is needed to launch.
    apply(mk("start2",     R | I_START,         ex(1, 2, 5, 0, 1, 1)));
    apply(mk("serve2_q",   R,                   ex(1, 2, 5, 0, 0, 0)));
    serve(2, 5, 8'h00);
    apply(mk("aim_right",  R | I_RIGHT,         ex(2, 3, 5, 0, 0, 0)));
    apply(mk("rst_aim",    I_RIGHT | I_FIRE,    ex(0, 2, 0, 0, 0, 0)));
    apply(mk("post_rst",   R | I_RIGHT | I_FIRE, ex(0, 2, 0, 0, 0, 0)));
    apply(mk("fire_held",  R | I_FIRE,          ex(0, 2, 0, 0, 0, 0)));
    apply(mk("start3",     R | I_FIRE | I_START, ex(1, 2, 5, 0, 1, 1)));
    serve(2, 5, I_FIRE);
    apply(mk("aim_fire_hold", R | I_FIRE,       ex(2, 2, 5, 0, 0, 0)));
    apply(mk("aim_fire_rel",  R,                ex(2, 2, 5, 0, 0, 0)));
    apply(mk("fresh_fire",    R | I_FIRE,       ex(3, 2, 5, 1, 0, 0)));
    apply(mk("rst_pulse",     I_LOST,           ex(0, 2, 0, 0, 0, 0)));
    apply(mk("idle_final",    R,                ex(0, 2, 0, 0, 0, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
